br_resolver: RTL

- Initiator side of the branch-stack recovery interface: collects resolved-branch results from the branch FUs and issues one BR_TASK (CLEAR or SQUASH) per cycle with its one-hot rem_b_id and recovery PC.
- Sits between the execute-stage branch units and the branch stack, ROB, SQ and fetch redirect.
- Orders recovery so the oldest mispredict squashes first and results from squashed branches are dropped.

---
 rtl/br_resolver.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/br_resolver.sv
// br_resolver: collects resolved-branch results and issues one BR_TASK (CLEAR/SQUASH) per cycle.
// Optional saturating statistics outputs are enabled with `define BR_RESOLVE_STATS_EN.
package sys_defs;
  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;
endpackage

module br_resolver
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned N     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            res_valid,
  input  logic [N-1:0][DEPTH-1:0] res_b_id,
  input  logic [N-1:0][DEPTH-1:0] res_b_mask,
  input  logic [N-1:0]            res_mispred,
  input  logic [N-1:0][31:0]      res_target,
  output BR_TASK                  br_task,
  output logic [DEPTH-1:0]        rem_b_id,
  output logic [31:0]             rec_pc,
  output logic [DEPTH-1:0]        pending,
  output logic                    idle
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]             stat_clears,
  output logic [31:0]             stat_squashes,
  output logic [31:0]             stat_dropped
`endif
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            r_mispred;
  logic [DEPTH-1:0][DEPTH-1:0] r_mask;
  logic [DEPTH-1:0][31:0]      r_target;
  BR_TASK                      r_task;
  logic [DEPTH-1:0]            r_rem;
  logic [31:0]                 r_pc;

  logic [DEPTH-1:0]            w_sq_id;
  logic [DEPTH-1:0]            w_cl_id;
  logic [DEPTH-1:0]            w_fvalid;
  logic [DEPTH-1:0][DEPTH-1:0] w_fmask;
  logic [DEPTH-1:0]            w_mp;
  logic [DEPTH-1:0]            w_ok;
  BR_TASK                      w_sel_task;
  logic [DEPTH-1:0]            w_sel_id;
  logic [31:0]                 w_sel_pc;
  logic [N-1:0]                w_drop;
  logic [DEPTH-1:0]            w_nvalid;
  logic [DEPTH-1:0]            w_nmisp;
  logic [DEPTH-1:0][DEPTH-1:0] w_nmask;
  logic [DEPTH-1:0][31:0]      w_ntarget;

  // The task currently on the outputs is what the branch stack acts on this cycle.
  assign w_sq_id = (r_task == SQUASH) ? r_rem : '0;
  assign w_cl_id = (r_task == CLEAR)  ? r_rem : '0;

  // Slots written at the edge that registered the current task still need its effect applied.
  always_comb begin : b_filter
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_fvalid[k] = r_valid[k] && !w_sq_id[k] && ((r_mask[k] & w_sq_id) == '0);
      w_fmask[k]  = r_mask[k] & ~w_cl_id;
    end
  end

  assign w_mp = w_fvalid & r_mispred;
  assign w_ok = w_fvalid & ~r_mispred;

  always_comb begin : b_select
    logic             found;
    logic [DEPTH-1:0] w_others;
    found      = 1'b0;
    w_others   = '0;
    w_sel_task = NOTHING;
    w_sel_id   = '0;
    w_sel_pc   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_others    = w_mp;
      w_others[k] = 1'b0;
      if (!found && w_mp[k] && ((w_fmask[k] & w_others) == '0)) begin
        found       = 1'b1;
        w_sel_task  = SQUASH;
        w_sel_id[k] = 1'b1;
        w_sel_pc    = r_target[k];
      end
    end
    // Any pending mispredict, even one stuck behind a malformed mask cycle, blocks CLEAR.
    if (w_mp == '0) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found && w_ok[k]) begin
          found       = 1'b1;
          w_sel_task  = CLEAR;
          w_sel_id[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin : b_drop
    for (int unsigned i = 0; i < N; i++) begin
      w_drop[i] = res_valid[i] &&
                  (((res_b_mask[i] & w_sq_id) != '0) || ((res_b_id[i] & w_sq_id) != '0));
    end
  end

  always_comb begin : b_update
    logic taken;
    taken     = 1'b0;
    w_nvalid  = w_fvalid & ~w_sel_id;
    w_nmisp   = r_mispred;
    w_nmask   = w_fmask;
    w_ntarget = r_target;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_sel_task == SQUASH && ((w_fmask[k] & w_sel_id) != '0))
        w_nvalid[k] = 1'b0;
      if (w_sel_task == CLEAR)
        w_nmask[k] = w_fmask[k] & ~w_sel_id;
    end
    // Lowest lane claims a slot; the claim still loses if it is filtered or the slot is occupied.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      taken = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        if (!taken && res_valid[i] && res_b_id[i][k]) begin
          taken = 1'b1;
          if (!w_drop[i] && !w_fvalid[k]) begin
            w_nvalid[k]  = 1'b1;
            w_nmisp[k]   = res_mispred[i];
            w_nmask[k]   = res_b_mask[i] & ~w_cl_id;
            w_ntarget[k] = res_target[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= '0;
      r_mispred <= '0;
      r_mask    <= '0;
      r_target  <= '0;
      r_task    <= NOTHING;
      r_rem     <= '0;
      r_pc      <= '0;
    end else begin
      r_valid   <= w_nvalid;
      r_mispred <= w_nmisp;
      r_mask    <= w_nmask;
      r_target  <= w_ntarget;
      r_task    <= w_sel_task;
      r_rem     <= w_sel_id;
      r_pc      <= w_sel_pc;
    end
  end

  assign br_task  = r_task;
  assign rem_b_id = r_rem;
  assign rec_pc   = r_pc;
  assign pending  = r_valid;
  assign idle     = (r_valid == '0);

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0]      r_clears;
  logic [31:0]      r_squashes;
  logic [31:0]      r_dropped;
  logic [31:0]      w_drop_cnt;
  logic [DEPTH-1:0] w_nkill;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Dropped = incoming lanes filtered + stored slots filtered + dependents killed by a new SQUASH.
  always_comb begin : b_stats
    w_drop_cnt = '0;
    w_nkill    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_nkill[k] = (w_sel_task == SQUASH) && w_fvalid[k] && !w_sel_id[k] &&
                   ((w_fmask[k] & w_sel_id) != '0);
      w_drop_cnt = w_drop_cnt + 32'(r_valid[k] & ~w_fvalid[k]) + 32'(w_nkill[k]);
    end
    for (int unsigned i = 0; i < N; i++)
      w_drop_cnt = w_drop_cnt + 32'(w_drop[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clears   <= '0;
      r_squashes <= '0;
      r_dropped  <= '0;
    end else begin
      r_clears   <= sat_add(r_clears,   32'(w_sel_task == CLEAR));
      r_squashes <= sat_add(r_squashes, 32'(w_sel_task == SQUASH));
      r_dropped  <= sat_add(r_dropped,  w_drop_cnt);
    end
  end

  assign stat_clears   = r_clears;
  assign stat_squashes = r_squashes;
  assign stat_dropped  = r_dropped;
`endif

endmodule
